// File: rtl/approx_pkg.sv
// Shared definitions for the approximate multiplier family and its downstream
// accumulator: product width and the accumulator FSM state encodings.
package approx_pkg;

   localparam int PROD_W = 16;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ACCUM = 2'd1;
   localparam state_t HOLD  = 2'd2;

endpackage

// File: rtl/sat_add_u.sv
// Unsigned saturating adder: acc + addend clamped to the all-ones value of
// ACC_W bits, with a flag reporting that the clamp was applied.
module sat_add_u
   import approx_pkg::*;
#(
   parameter int ACC_W = 24
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] addend,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] wide;

   always_comb begin
      wide = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
      ovf  = wide[ACC_W];
      sum  = ovf ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
   end

endmodule

// File: rtl/approx_dot_accum.sv
// Frame accumulator for the approximate product stream: sums cfg_len products
// per frame with saturation and presents one held result per frame.
module approx_dot_accum
   import approx_pkg::*;
#(
   parameter int ACC_W = 24,
   parameter int LEN_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_sat
);

   state_t             state_reg, state_next;
   logic [LEN_W:0]     len_reg, len_next;
   logic [LEN_W:0]     cnt_reg, cnt_next;
   logic [ACC_W-1:0]   acc_reg, acc_next;
   logic               sat_reg, sat_next;

   logic               accept;
   logic               start_frame;
   logic [LEN_W:0]     first_len;
   logic [LEN_W:0]     cnt_inc;
   logic [ACC_W-1:0]   add_sum;
   logic               add_ovf;

   sat_add_u #(.ACC_W(ACC_W)) u_sat_add (
      .acc    (acc_reg),
      .addend (in_prod),
      .sum    (add_sum),
      .ovf    (add_ovf)
   );

   // In HOLD a new beat may only enter when the held result leaves the same cycle.
   assign in_ready  = !rst && (state_reg != HOLD || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_reg == HOLD);
   assign out_acc   = acc_reg;
   assign out_sat   = sat_reg;

   always_comb begin
      first_len   = (cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cfg_len};
      cnt_inc     = cnt_reg + {{LEN_W{1'b0}}, 1'b1};
      start_frame = accept && (state_reg == IDLE || state_reg == HOLD);

      state_next = state_reg;
      len_next   = len_reg;
      cnt_next   = cnt_reg;
      acc_next   = acc_reg;
      sat_next   = sat_reg;

      case (state_reg)
         ACCUM: begin
            if (accept) begin
               acc_next = add_sum;
               sat_next = sat_reg | add_ovf;
               cnt_next = cnt_inc;
               if (cnt_inc == len_reg) begin
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         IDLE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // The first beat of a frame overrides whatever the case chose.
      if (start_frame) begin
         len_next   = first_len;
         cnt_next   = {{LEN_W{1'b0}}, 1'b1};
         acc_next   = {{(ACC_W - PROD_W){1'b0}}, in_prod};
         sat_next   = 1'b0;
         state_next = (first_len == {{LEN_W{1'b0}}, 1'b1}) ? HOLD : ACCUM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         len_reg   <= '0;
         cnt_reg   <= '0;
         acc_reg   <= '0;
         sat_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         len_reg   <= len_next;
         cnt_reg   <= cnt_next;
         acc_reg   <= acc_next;
         sat_reg   <= sat_next;
      end
   end

endmodule
